// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: opcode, FSM state and ALU-op encodings for the
// accumulator CPU. Optional SUB is enabled by ACC_CPU_SUB_EN.
package acc_cpu_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_LDA = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_SUB = 3'b011,
    OP_STA = 3'b100,
    OP_JMP = 3'b101,
    OP_JZ  = 3'b110,
    OP_HLT = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_AND,
    ALU_SUB
  } alu_op_e;

  function automatic logic writes_carry(
    input alu_op_e op
  );
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational ALU for the accumulator CPU.
// The subtractor exists only when ACC_CPU_SUB_EN is defined.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_operand,
  input  alu_op_e           i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, i_acc} + {1'b0, i_operand};

`ifdef ACC_CPU_SUB_EN
  // Top bit of the widened difference is the borrow.
  logic [DATA_W:0] w_diff;

  assign w_diff = {1'b0, i_acc} - {1'b0, i_operand};
`endif

  always_comb begin
    o_result = i_operand;
    o_carry  = 1'b0;
    unique case (i_op)
      ALU_PASS: o_result = i_operand;
      ALU_ADD:  {o_carry, o_result} = w_sum;
      ALU_AND:  o_result = i_acc & i_operand;
`ifdef ACC_CPU_SUB_EN
      ALU_SUB:  {o_carry, o_result} = w_diff;
`endif
      default:  o_result = i_operand;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU with req/ack memory.
// Opcode 011 is SUB with ACC_CPU_SUB_EN defined, else a NOP.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int ADDR_W = DATA_W - 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] out_acc,
  output logic              carry,
  output logic              halted
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_acc;
  logic                r_carry;

  opcode_e             w_op;
  logic [ADDR_W-1:0]   w_addr;
  alu_op_e             w_alu_op;
  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_carry;
  logic                w_req;

  assign w_op   = opcode_e'(r_ir[DATA_W-1 -: OPC_W]);
  assign w_addr = r_ir[ADDR_W-1:0];
  assign w_req  = (r_state == ST_FETCH) ||
                  (r_state == ST_EXEC);

  always_comb begin
    w_alu_op = ALU_PASS;
    unique case (w_op)
      OP_ADD:  w_alu_op = ALU_ADD;
      OP_AND:  w_alu_op = ALU_AND;
`ifdef ACC_CPU_SUB_EN
      OP_SUB:  w_alu_op = ALU_SUB;
`endif
      default: w_alu_op = ALU_PASS;
    endcase
  end

  acc_cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_acc     (r_acc),
    .i_operand (mem_rdata),
    .i_op      (w_alu_op),
    .o_result  (w_alu_res),
    .o_carry   (w_alu_carry)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else begin
      unique case (r_state)
        ST_FETCH: begin
          if (mem_ack) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          unique case (w_op)
            OP_JMP: begin
              r_pc    <= w_addr;
              r_state <= ST_FETCH;
            end
            OP_JZ: begin
              if (r_acc == '0) begin
                r_pc <= w_addr;
              end
              r_state <= ST_FETCH;
            end
            OP_HLT:  r_state <= ST_HALT;
`ifndef ACC_CPU_SUB_EN
            OP_SUB:  r_state <= ST_FETCH;
`endif
            default: r_state <= ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          if (mem_ack) begin
            if (w_op != OP_STA) begin
              r_acc <= w_alu_res;
            end
            if (writes_carry(w_alu_op)) begin
              r_carry <= w_alu_carry;
            end
            r_state <= ST_FETCH;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Outputs are forced low while reset is held.
  assign mem_req   = !reset && w_req;
  assign mem_we    = !reset && (r_state == ST_EXEC) &&
                     (w_op == OP_STA);
  assign mem_addr  = reset ? '0 :
                     (r_state == ST_EXEC) ? w_addr : r_pc;
  assign mem_wdata = reset ? '0 : r_acc;
  assign out_acc   = reset ? '0 : r_acc;
  assign carry     = !reset && r_carry;
  assign halted    = !reset && (r_state == ST_HALT);

endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: scoreboard bench; an instruction-level model
// predicts every bus transfer and the final machine state.
module tb_acc_cpu_core;

  localparam int DW  = 8;
  localparam int AW  = DW - 3;
  localparam int MW  = 1 << AW;
  localparam int MOD = 1 << DW;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] out_acc;
  logic          carry;
  logic          halted;

  logic [DW-1:0] mem     [MW];
  logic [DW-1:0] prog    [MW];
  logic [DW-1:0] exp_mem [MW];
  xfer_t         exp_q[$];

  int            checks = 0;
  int            errors = 0;
  bit            auto_mode = 1'b0;
  logic          man_ack = 1'b0;
  int            budget = 0;
  int            max_stall = 0;
  int            stall = 0;
  logic [DW-1:0] exp_acc;
  logic          exp_carry;
  bit            exp_halt;

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];

  acc_cpu_core #(
    .DATA_W   (DW),
    .RESET_PC (5'd0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .out_acc   (out_acc),
    .carry     (carry),
    .halted    (halted)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic xfer_t mk(input logic          we,
                               input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    xfer_t x;
    x.we   = we;
    x.addr = a;
    x.data = d;
    return x;
  endfunction

  // Instruction-level interpreter over a private memory copy.
  task automatic model_run(input int max_instr);
    logic [DW-1:0] mm [MW];
    logic [AW-1:0] pc;
    logic [AW-1:0] a;
    logic [DW-1:0] acc;
    logic [DW-1:0] ins;
    logic [DW-1:0] opnd;
    logic          c;
    bit            h;
    int            s;
    pc  = '0;
    acc = '0;
    c   = 1'b0;
    h   = 1'b0;
    for (int i = 0; i < MW; i++) mm[i] = prog[i];
    exp_q.delete();
    for (int n = 0; n < max_instr && !h; n++) begin
      ins = mm[pc];
      exp_q.push_back(mk(1'b0, pc, '0));
      pc   = pc + AW'(1);
      a    = ins[AW-1:0];
      opnd = mm[a];
      case (ins[DW-1 -: 3])
        3'd0: begin
          exp_q.push_back(mk(1'b0, a, '0));
          acc = opnd;
        end
        3'd1: begin
          exp_q.push_back(mk(1'b0, a, '0));
          s   = int'(acc) + int'(opnd);
          c   = (s >= MOD);
          acc = DW'(s % MOD);
        end
        3'd2: begin
          exp_q.push_back(mk(1'b0, a, '0));
          acc = acc & opnd;
        end
        3'd3: begin
`ifdef ACC_CPU_SUB_EN
          exp_q.push_back(mk(1'b0, a, '0));
          c   = (acc < opnd);
          s   = int'(acc) - int'(opnd) + MOD;
          acc = DW'(s % MOD);
`endif
        end
        3'd4: begin
          exp_q.push_back(mk(1'b1, a, acc));
          mm[a] = acc;
        end
        3'd5: pc = a;
        3'd6: if (acc == '0) pc = a;
        default: h = 1'b1;
      endcase
    end
    exp_acc   = acc;
    exp_carry = c;
    exp_halt  = h;
    for (int i = 0; i < MW; i++) exp_mem[i] = mm[i];
  endtask

  // Memory responder: random stalls, random ack while idle.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (!auto_mode) begin
        mem_ack = man_ack;
      end else if (mem_req && !reset) begin
        if (stall > 0 || budget == 0) begin
          mem_ack = 1'b0;
          if (stall > 0) stall--;
        end else begin
          mem_ack = 1'b1;
          budget--;
          if (mem_we) mem[mem_addr] = mem_wdata;
          stall = int'($urandom_range(max_stall, 0));
        end
      end else begin
        mem_ack = (($urandom % 2) == 1);
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted transfer.
  initial begin
    bit    pw;
    xfer_t pv;
    xfer_t cur;
    xfer_t e;
    pw = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      cur = mk(mem_we, mem_addr, mem_wdata);
      if (auto_mode && !reset) begin
        if (pw) chk("stable_while_wait",
                    {mem_req, cur}, {1'b1, pv});
        pw = mem_req && !mem_ack;
        pv = cur;
        if (mem_req && mem_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_xfer: got %0h expected none",
                     cur);
          end else begin
            e = exp_q.pop_front();
            if (!cur.we) cur.data = '0;
            chk("xfer", cur, e);
          end
        end
      end else begin
        pw = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("reset_outputs",
        {mem_req, mem_we, mem_addr, mem_wdata,
         out_acc, carry, halted}, '0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_prog(input string name,
                          input int max_instr,
                          input int ms,
                          input int exp_cyc);
    int cyc;
    int hc;
    int bad;
    cyc = 0;
    hc  = -1;
    bad = 0;
    model_run(max_instr);
    for (int i = 0; i < MW; i++) mem[i] = prog[i];
    max_stall = ms;
    stall     = int'($urandom_range(ms, 0));
    budget    = exp_q.size();
    auto_mode = 1'b1;
    do_reset();
    while ((budget > 0 || exp_q.size() > 0) && cyc < 5000) begin
      @(negedge clock);
      #3;
      cyc++;
      if (halted && hc < 0) hc = cyc;
    end
    if (cyc >= 5000) begin
      chk({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (3) begin
      @(negedge clock);
      #3;
      cyc++;
      if (halted && hc < 0) hc = cyc;
    end
    chk({name, "_acc"}, out_acc, exp_acc);
    chk({name, "_carry"}, carry, exp_carry);
    chk({name, "_halted"}, halted, exp_halt);
    for (int i = 0; i < MW; i++) begin
      if (mem[i] !== exp_mem[i]) bad++;
    end
    chk({name, "_mem_bad_words"}, bad, 0);
    if (exp_cyc > 0) chk({name, "_latency"}, hc, exp_cyc);
    auto_mode = 1'b0;
  endtask

  task automatic clr_prog();
    for (int i = 0; i < MW; i++) prog[i] = '0;
  endtask

  task automatic reset_mid_exec();
    clr_prog();
    prog[0]  = 8'h0A;
    prog[1]  = 8'h0B;
    prog[2]  = 8'hE0;
    prog[10] = 8'h5A;
    prog[11] = 8'h3C;
    for (int i = 0; i < MW; i++) mem[i] = prog[i];
    auto_mode = 1'b0;
    man_ack   = 1'b1;
    do_reset();
    repeat (4) @(negedge clock);
    man_ack = 1'b0;
    @(negedge clock);
    #3;
    chk("rst_exec_bus", {mem_req, mem_we, mem_addr},
        {1'b1, 1'b0, 5'd11});
    chk("rst_exec_acc", out_acc, 8'h5A);
    @(negedge clock);
    reset   = 1'b1;
    man_ack = 1'b1;
    #3;
    chk("rst_mid_outputs",
        {mem_req, mem_we, mem_addr, out_acc, halted}, '0);
    @(negedge clock);
    reset   = 1'b0;
    man_ack = 1'b0;
    #3;
    chk("rst_refetch", {mem_req, mem_we, mem_addr, out_acc},
        {1'b1, 1'b0, 5'd0, 8'h00});
    @(negedge clock);
    #3;
    chk("rst_stale_ack", {mem_req, mem_we, mem_addr, out_acc},
        {1'b1, 1'b0, 5'd0, 8'h00});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_prog();
    prog[0]  = 8'h0A;
    prog[1]  = 8'h2B;
    prog[2]  = 8'h8C;
    prog[3]  = 8'hE0;
    prog[10] = 8'h05;
    prog[11] = 8'h07;
    run_prog("basic", 20, 0, 11);
    chk("basic_sum_stored", mem[12], 8'h0C);
    run_prog("basic_stall", 20, 4, 0);
    chk("stall_sum_stored", mem[12], 8'h0C);

    clr_prog();
    prog[0]  = 8'h0A;
    prog[1]  = 8'h2B;
    prog[2]  = 8'hE0;
    prog[10] = 8'hFF;
    prog[11] = 8'h02;
    run_prog("overflow", 20, 0, 0);
    chk("overflow_flags", {carry, out_acc}, {1'b1, 8'h01});

    clr_prog();
    prog[0]  = 8'h0C;
    prog[1]  = 8'h2D;
    prog[2]  = 8'h0A;
    prog[3]  = 8'h6B;
    prog[4]  = 8'hE0;
    prog[10] = 8'h03;
    prog[11] = 8'h05;
    prog[12] = 8'hFF;
    prog[13] = 8'h01;
    run_prog("sub", 20, 2, 0);
`ifdef ACC_CPU_SUB_EN
    chk("sub_result", {carry, out_acc}, {1'b1, 8'hFE});
`else
    chk("sub_nop", {carry, out_acc}, {1'b1, 8'h03});
`endif

    clr_prog();
    prog[0]  = 8'h0F;
    prog[1]  = 8'hD4;
    prog[2]  = 8'hE0;
    prog[15] = 8'h00;
    prog[16] = 8'h01;
    prog[20] = 8'h10;
    prog[21] = 8'hD9;
    prog[22] = 8'hA0;
    prog[25] = 8'hE0;
    run_prog("jz_loop", 12, 1, 0);

    clr_prog();
    prog[0]  = 8'hBE;
    prog[30] = 8'h0A;
    prog[31] = 8'h2B;
    prog[10] = 8'h03;
    prog[11] = 8'h04;
    run_prog("pc_wrap", 7, 0, 0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < MW; i++) prog[i] = DW'($urandom);
      run_prog("random", 40, 4, 0);
    end

    reset_mid_exec();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
Parametrised successor to the 8-bit adding machine: a multi-cycle accumulator CPU with its controller and datapath merged into one block. It fetches instructions from a shared memory over a req/ack handshake and executes 8 opcodes. It adds SUB, AND, STA and conditional jump, a carry flag, and a halt state. It sits between the system memory/bus model and the top-level test harness.

Parameters:
DATA_W, 8, accumulator/memory word width; legal range 5..32. ADDR_W = DATA_W-3 is a derived localparam.
RESET_PC, 0, PC value loaded on reset; width ADDR_W.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
mem_req  out  1  memory transfer request; held until accepted
mem_we  out  1  1=write, 0=read; valid while mem_req
mem_addr  out  ADDR_W  transfer address; stable while mem_req
mem_wdata  out  DATA_W  store data (acc); valid while mem_req&&mem_we
mem_rdata  in  DATA_W  read data; sampled in the accept cycle
mem_ack  in  1  accept; a transfer completes on any cycle with mem_req&&mem_ack
out_acc  out  DATA_W  accumulator
carry  out  1  carry/borrow flag
halted  out  1  high in HALT state

Behaviour:
- Instruction word: opcode = [DATA_W-1:DATA_W-3]; address = [ADDR_W-1:0].
- Opcodes: 000 LDA, 001 ADD, 010 AND, 011 SUB, 100 STA, 101 JMP, 110 JZ, 111 HLT.
- Reset values: pc=RESET_PC, acc=0, carry=0, ir=0, state=FETCH. All outputs are 0 during the reset cycle, including mem_req.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc.
  - On accept: ir<=mem_rdata, pc<=pc+1 (wraps modulo 2^ADDR_W), then go to DECODE.
- DECODE (1 cycle, no request):
  - JMP: pc<=addr, go to FETCH.
  - JZ: if acc==0 then pc<=addr; go to FETCH either way.
  - HLT: go to HALT.
  - LDA, ADD, AND, SUB: go to EXEC as a read of addr.
  - STA: go to EXEC as a write of acc to addr.
- EXEC: mem_req=1, mem_addr=ir addr. On accept:
  - LDA: acc<=rdata.
  - ADD: {carry,acc}<=acc+rdata.
  - SUB: acc<=acc-rdata; carry<=1 if borrow (acc<rdata).
  - AND: acc<=acc&rdata.
  - STA: memory is written; acc is unchanged.
  - Then go to FETCH.
  - carry changes only on ADD and SUB.
- HALT: halted=1, mem_req=0. Only reset leaves this state.
- Latency with zero-wait memory (ack held high): memory ops take 3 cycles/instruction; JMP, JZ and HLT take 2.
- Each wait cycle (ack low) extends FETCH or EXEC by one cycle. mem_addr, mem_we and mem_wdata do not change while waiting.
- mem_ack while mem_req=0 is ignored.
- Reset asserted mid-transfer: the transfer is abandoned; a later ack belonging to it is ignored.
- PC wrap: a fetch at address 2^ADDR_W-1 leaves pc=0.
- Arithmetic wraps modulo 2^DATA_W.

Optional Feature:
ACC_CPU_SUB_EN. Defined: opcode 011 executes SUB as specified. Undefined: 011 decodes as NOP (DECODE goes straight to FETCH, no data access, acc and carry unchanged), and no subtractor is synthesised.

Decomposition:
- Package acc_cpu_pkg: opcode enum (3-bit), FSM state enum (FETCH, DECODE, EXEC, HALT), ALU-op enum.
- Sub-module acc_cpu_alu: combinational. Inputs are acc, operand and alu op; outputs are result and carry_out. Parametrised by DATA_W.
- The FSM, pc, ir and acc registers stay in acc_cpu_core.

Test Plan:
- Reset, then ack held high. Program at 0: LDA 10; ADD 11; STA 12; HLT. Data: mem[10]=0x05, mem[11]=0x07. Required: mem[12]=0x0C, halted=1, out_acc=0x0C, carry=0, 11 cycles from the first fetch to halted.
- Overflow: mem[10]=0xFF, mem[11]=0x02, then LDA/ADD. Required: acc=0x01, carry=1.
- SUB with ACC_CPU_SUB_EN: acc=0x03 minus 0x05. Required: acc=0xFE, carry=1. Same program without the macro: acc=0x03, carry unchanged, pc advances.
- JZ: acc=0 with JZ 20 → next fetch address 20. acc=1 → falls through to pc+1. JMP 0 produces a loop.
- Random ack stalls of 0–4 cycles: mem_addr, mem_we and mem_wdata remain stable while mem_req is high. Final memory and acc values match the zero-wait run.
- Reset asserted during EXEC wait, with a stale ack following. Required: next request is FETCH at RESET_PC, acc=0, and the stale ack has no effect.
